// File: rtl/kuz_pkg.sv
// rtl/kuz_pkg.sv - Kuznyechik shared widths, state enum, S-box, L helpers and round constants
package kuz_pkg;

  localparam int BLK_W         = 128;
  localparam int FEISTEL_STEPS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONST = 3'd1,
    XOR   = 3'd2,
    SUB   = 3'd3,
    LWAIT = 3'd4,
    SWAP  = 3'd5,
    DONE  = 3'd6
  } kx_state_t;

  typedef logic [0:255][7:0]      pi_table_t;
  typedef logic [1:32][BLK_W-1:0] c_table_t;

  // Pi substitution, row-major: entry 0 is the leftmost byte of the first row
  localparam pi_table_t KUZ_PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
    128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F,
    128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC,
    128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1,
    128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903,
    128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641,
    128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789,
    128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52,
    128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // Linear-map coefficients, index 0 pairs with the most significant byte
  localparam logic [0:15][7:0] L_COEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // GF(2^8) multiply modulo x^8 + x^7 + x^6 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
    end
    return p;
  endfunction

  // One R round: new top byte is the linear combination, lowest byte drops out
  function automatic logic [BLK_W-1:0] r_step(input logic [BLK_W-1:0] a);
    logic [7:0] acc;
    acc = 8'h00;
    for (int j = 0; j < 16; j++) begin
      acc = acc ^ gf_mul(L_COEF[j], a[8*(15-j) +: 8]);
    end
    return {acc, a[BLK_W-1:8]};
  endfunction

  function automatic logic [BLK_W-1:0] l_full(input logic [BLK_W-1:0] a);
    logic [BLK_W-1:0] v;
    v = a;
    for (int r = 0; r < 16; r++) v = r_step(v);
    return v;
  endfunction

  // Round constants C_i = L(Vec128(i)), evaluated at elaboration
  function automatic c_table_t gen_consts();
    c_table_t tbl;
    for (int k = 1; k <= 32; k++) begin
      tbl[k] = l_full(BLK_W'(k));
    end
    return tbl;
  endfunction

  localparam c_table_t KUZ_C = gen_consts();

endpackage

// File: rtl/L_convertion.sv
// rtl/L_convertion.sv - iterative L transform, one R round per cycle, level enable/finish handshake
module L_convertion
  import kuz_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [BLK_W-1:0] data_in,
  output logic [BLK_W-1:0] data_out,
  output logic             finish
);

  logic [3:0] round;
  logic       busy;

  // Load and first round on enable, 15 more rounds, then hold finish until enable drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      round    <= 4'd0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else if (!enable) begin
      round    <= 4'd0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else if (!busy && !finish) begin
      data_out <= r_step(data_in);
      round    <= 4'd1;
      busy     <= 1'b1;
    end else if (busy) begin
      data_out <= r_step(data_out);
      round    <= round + 4'd1;
      if (round == 4'd15) begin
        busy   <= 1'b0;
        finish <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/kuz_s_layer.sv
// rtl/kuz_s_layer.sv - 128-bit S layer built from 16 byte substitution tables
module kuz_s_layer
  import kuz_pkg::*;
(
  input  logic [BLK_W-1:0] data_in,
  output logic [BLK_W-1:0] data_out
);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    table_convertion u_tbl (
      .data_in  (data_in[8*g +: 8]),
      .data_out (data_out[8*g +: 8])
    );
  end

endmodule

// File: rtl/table_convertion.sv
// rtl/table_convertion.sv - single-byte Kuznyechik Pi substitution
module table_convertion
  import kuz_pkg::*;
(
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  assign data_out = KUZ_PI[data_in];

endmodule

// File: rtl/key_expander.sv
// rtl/key_expander.sv - Kuznyechik key schedule; KEY_CONST_ROM_EN selects table constants over on-chip L(i)
module key_expander
  import kuz_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [255:0]     master_key,
  output logic [BLK_W-1:0] key_1,
  output logic [BLK_W-1:0] key_2,
  output logic [BLK_W-1:0] key_3,
  output logic [BLK_W-1:0] key_4,
  output logic [BLK_W-1:0] key_5,
  output logic [BLK_W-1:0] key_6,
  output logic [BLK_W-1:0] key_7,
  output logic [BLK_W-1:0] key_8,
  output logic [BLK_W-1:0] key_9,
  output logic [BLK_W-1:0] key_10,
  output logic             finish
);

  kx_state_t        state;
  logic [5:0]       i;
  logic [BLK_W-1:0] a1;
  logic [BLK_W-1:0] a0;
  logic [BLK_W-1:0] t;
  logic [BLK_W-1:0] c_reg;
  logic [BLK_W-1:0] s_out;
  logic [BLK_W-1:0] l_in;
  logic [BLK_W-1:0] l_out;
  logic [BLK_W-1:0] a1_next;
  logic             l_en;
  logic             l_finish;

  kuz_s_layer u_s_layer (
    .data_in  (t),
    .data_out (s_out)
  );

`ifdef KEY_CONST_ROM_EN
  assign l_in = t;
`else
  // The shared L unit computes C_i from Vec128(i) while in CONST, otherwise transforms t
  assign l_in = (state == CONST) ? {{(BLK_W-6){1'b0}}, i} : t;
`endif

  L_convertion u_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (l_en),
    .data_in  (l_in),
    .data_out (l_out),
    .finish   (l_finish)
  );

  assign a1_next = t ^ a0;

  // Key-schedule sequencer: one Feistel step per CONST..SWAP pass, keys stored every 8th step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      i      <= 6'd0;
      a1     <= '0;
      a0     <= '0;
      t      <= '0;
      c_reg  <= '0;
      l_en   <= 1'b0;
      finish <= 1'b0;
      key_1  <= '0;
      key_2  <= '0;
      key_3  <= '0;
      key_4  <= '0;
      key_5  <= '0;
      key_6  <= '0;
      key_7  <= '0;
      key_8  <= '0;
      key_9  <= '0;
      key_10 <= '0;
    end else begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (enable) begin
            a1    <= master_key[255:128];
            a0    <= master_key[127:0];
            key_1 <= master_key[255:128];
            key_2 <= master_key[127:0];
            i     <= 6'd1;
            state <= CONST;
          end
        end
        CONST: begin
`ifdef KEY_CONST_ROM_EN
          c_reg <= KUZ_C[i];
          state <= XOR;
`else
          if (!l_en) begin
            l_en <= 1'b1;
          end else if (l_finish) begin
            c_reg <= l_out;
            l_en  <= 1'b0;
            state <= XOR;
          end
`endif
        end
        XOR: begin
          t     <= a1 ^ c_reg;
          state <= SUB;
        end
        SUB: begin
          t     <= s_out;
          l_en  <= 1'b1;
          state <= LWAIT;
        end
        LWAIT: begin
          if (l_finish) begin
            t     <= l_out;
            l_en  <= 1'b0;
            state <= SWAP;
          end
        end
        SWAP: begin
          a1 <= a1_next;
          a0 <= a1;
          i  <= i + 6'd1;
          if (i[2:0] == 3'd0) begin
            case (i[5:3])
              3'd1: begin key_3 <= a1_next; key_4  <= a1; end
              3'd2: begin key_5 <= a1_next; key_6  <= a1; end
              3'd3: begin key_7 <= a1_next; key_8  <= a1; end
              3'd4: begin key_9 <= a1_next; key_10 <= a1; end
              default: ;
            endcase
          end
          state <= (i == 6'(FEISTEL_STEPS)) ? DONE : CONST;
        end
        DONE: begin
          // Leave on enable low; if it was already low on arrival, finish still shows for one cycle
          if (finish && !enable) begin
            finish <= 1'b0;
            state  <= IDLE;
          end else begin
            finish <= 1'b1;
            if (!enable) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// tb/tb_key_expander.sv - self-checking bench for key_expander against a behavioural key-schedule model
module tb_key_expander;
  import kuz_pkg::*;

  // L unit: 16 R rounds at one per cycle plus the cycle in which its finish is consumed
  localparam int L_CYC = 17;
`ifdef KEY_CONST_ROM_EN
  localparam int PER_STEP = 4 + L_CYC;
`else
  localparam int PER_STEP = 4 + 2 * L_CYC;
`endif
  localparam int TOTAL = 1 + 32 * PER_STEP + 1;

  localparam logic [255:0] STD_KEY =
    256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [7:0] TB_COEF [16] = '{148, 32, 133, 16, 194, 192, 1, 251,
                                          1, 192, 194, 16, 133, 32, 148, 1};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [255:0] master_key = '0;
  logic [127:0] key_1, key_2, key_3, key_4, key_5, key_6, key_7, key_8, key_9, key_10;
  logic         finish;

  logic [127:0] exp_key [1:10];
  int n_cmp = 0;
  int n_bad = 0;

  key_expander dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .master_key(master_key),
    .key_1(key_1), .key_2(key_2), .key_3(key_3), .key_4(key_4), .key_5(key_5),
    .key_6(key_6), .key_7(key_7), .key_8(key_8), .key_9(key_9), .key_10(key_10),
    .finish(finish)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] dut_key(input int n);
    case (n)
      1: return key_1;   2: return key_2;   3: return key_3;   4: return key_4;
      5: return key_5;   6: return key_6;   7: return key_7;   8: return key_8;
      9: return key_9;   10: return key_10; default: return '0;
    endcase
  endfunction

  // Polynomial product then long division by 0x1C3
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h01C3 << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] m_L(input logic [127:0] x);
    logic [127:0] a;
    logic [7:0] s;
    a = x;
    for (int r = 0; r < 16; r++) begin
      s = 8'h00;
      for (int j = 0; j < 16; j++) s = s ^ m_mul(TB_COEF[j], a[8*(15-j) +: 8]);
      a = {s, a[127:8]};
    end
    return a;
  endfunction

  function automatic logic [127:0] m_S(input logic [127:0] x);
    logic [127:0] y;
    for (int j = 0; j < 16; j++) y[8*j +: 8] = KUZ_PI[x[8*j +: 8]];
    return y;
  endfunction

  task automatic model_expand(input logic [255:0] mk);
    logic [127:0] x1, x0, f;
    x1 = mk[255:128];
    x0 = mk[127:0];
    exp_key[1] = x1;
    exp_key[2] = x0;
    for (int s = 1; s <= 32; s++) begin
      f = m_L(m_S(x1 ^ m_L(128'(s)))) ^ x0;
      x0 = x1;
      x1 = f;
      if (s % 8 == 0) begin
        exp_key[2 * (s / 8) + 1] = x1;
        exp_key[2 * (s / 8) + 2] = x0;
      end
    end
  endtask

  task automatic start_run(input logic [255:0] mk);
    @(negedge clk);
    master_key = mk;
    enable = 1'b1;
  endtask

  task automatic wait_finish(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!finish && cyc < budget);
  endtask

  task automatic go_idle();
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b expected 0", finish); end
    for (int n = 1; n <= 10; n++) begin
      n_cmp++;
      if (dut_key(n) !== 128'h0) begin
        n_bad++; $display("FAIL reset_key_%0d: got %h expected 0", n, dut_key(n));
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_standard();
    int cyc;
    model_expand(STD_KEY);
    start_run(STD_KEY);
    wait_finish(TOTAL + 20, cyc);
    n_cmp++;
    if (finish !== 1'b1) begin n_bad++; $display("FAIL std_finish: got %b expected 1", finish); end
    n_cmp++;
    if (cyc !== TOTAL) begin n_bad++; $display("FAIL std_latency: got %0d expected %0d", cyc, TOTAL); end
    n_cmp++;
    if (key_1 !== 128'h8899aabbccddeeff0011223344556677) begin n_bad++; $display("FAIL std_key_1: got %h", key_1); end
    n_cmp++;
    if (key_2 !== 128'hfedcba98765432100123456789abcdef) begin n_bad++; $display("FAIL std_key_2: got %h", key_2); end
    n_cmp++;
    if (key_3 !== 128'hdb31485315694343228d6aef8cc78c44) begin n_bad++; $display("FAIL std_key_3: got %h", key_3); end
    n_cmp++;
    if (key_4 !== 128'h3d4553d8e9cfec6815ebadc40a9ffd04) begin n_bad++; $display("FAIL std_key_4: got %h", key_4); end
    n_cmp++;
    if (key_9 !== 128'hbb44e25378c73123a5f32f73cdb6e517) begin n_bad++; $display("FAIL std_key_9: got %h", key_9); end
    n_cmp++;
    if (key_10 !== 128'h72e9dd7416bcf45b755dbaa88e4a4043) begin n_bad++; $display("FAIL std_key_10: got %h", key_10); end
    for (int n = 5; n <= 8; n++) begin
      n_cmp++;
      if (dut_key(n) !== exp_key[n]) begin
        n_bad++; $display("FAIL std_key_%0d: got %h expected %h", n, dut_key(n), exp_key[n]);
      end
    end
  endtask

  task automatic test_handshake();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (finish !== 1'b1 || key_3 !== exp_key[3] || key_10 !== exp_key[10]) begin
        n_bad++; $display("FAIL hold_stable: finish=%b key_3=%h key_10=%h", finish, key_3, key_10);
      end
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (finish !== 1'b0) begin n_bad++; $display("FAIL drop_finish: got %b expected 0", finish); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_const_c1();
    int cyc;
    bit seen;
    seen = 1'b0;
    start_run(STD_KEY);
    for (int c = 0; c < 4 * PER_STEP && !seen; c++) begin
      @(posedge clk); #1;
      if (dut.state == XOR) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || dut.c_reg !== 128'h6ea276726c487ab85d27bd10dd849401) begin
      n_bad++; $display("FAIL const_c1: reached=%b got %h expected 6ea276726c487ab85d27bd10dd849401", seen, dut.c_reg);
    end
    wait_finish(TOTAL + 20, cyc);
    n_cmp++;
    if (finish !== 1'b1) begin n_bad++; $display("FAIL const_run_finish: got %b expected 1", finish); end
    go_idle();
  endtask

  task automatic test_pulse();
    int cyc, hi;
    logic [255:0] mk;
    mk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    model_expand(mk);
    start_run(mk);
    @(negedge clk);
    enable = 1'b0;
    wait_finish(TOTAL + 20, cyc);
    hi = 0;
    while (finish === 1'b1 && hi < 5) begin
      hi++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (hi !== 1) begin n_bad++; $display("FAIL pulse_width: got %0d cycles expected 1", hi); end
    for (int n = 1; n <= 10; n++) begin
      n_cmp++;
      if (dut_key(n) !== exp_key[n]) begin
        n_bad++; $display("FAIL pulse_key_%0d: got %h expected %h", n, dut_key(n), exp_key[n]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_midrun_reset();
    int cyc;
    start_run(STD_KEY);
    repeat (1 + 16 * PER_STEP + 3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (finish !== 1'b0) begin n_bad++; $display("FAIL midrst_finish: got %b expected 0", finish); end
    for (int n = 1; n <= 10; n++) begin
      n_cmp++;
      if (dut_key(n) !== 128'h0) begin
        n_bad++; $display("FAIL midrst_key_%0d: got %h expected 0", n, dut_key(n));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_expand(STD_KEY);
    wait_finish(TOTAL + 20, cyc);
    for (int n = 1; n <= 10; n++) begin
      n_cmp++;
      if (dut_key(n) !== exp_key[n]) begin
        n_bad++; $display("FAIL rerun_key_%0d: got %h expected %h", n, dut_key(n), exp_key[n]);
      end
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] prev3;
    logic [255:0] mk;
    mk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    model_expand(mk);
    start_run(mk);
    wait_finish(TOTAL + 20, cyc);
    prev3 = exp_key[3];
    @(negedge clk);
    enable = 1'b0;
    model_expand(256'h0);
    start_run(256'h0);
    @(posedge clk); #1;
    n_cmp++;
    if (key_1 !== 128'h0 || key_2 !== 128'h0 || key_3 !== prev3) begin
      n_bad++; $display("FAIL b2b_start: key_1=%h key_2=%h key_3=%h expected key_3 %h", key_1, key_2, key_3, prev3);
    end
    wait_finish(TOTAL + 20, cyc);
    for (int n = 1; n <= 10; n++) begin
      n_cmp++;
      if (dut_key(n) !== exp_key[n]) begin
        n_bad++; $display("FAIL b2b_key_%0d: got %h expected %h", n, dut_key(n), exp_key[n]);
      end
    end
    go_idle();
  endtask

  task automatic test_random();
    int cyc;
    logic [255:0] mk;
    for (int r = 0; r < 3; r++) begin
      mk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(mk);
      start_run(mk);
      wait_finish(TOTAL + 20, cyc);
      n_cmp++;
      if (cyc !== TOTAL) begin n_bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, cyc, TOTAL); end
      for (int n = 1; n <= 10; n++) begin
        n_cmp++;
        if (dut_key(n) !== exp_key[n]) begin
          n_bad++; $display("FAIL rand%0d_key_%0d: got %h expected %h", r, n, dut_key(n), exp_key[n]);
        end
      end
      go_idle();
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_handshake();
    test_const_c1();
    test_pulse();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
